// File: rtl/bram_host_responder.sv
// Responder end of pe_con's byte-addressed BRAM port: loads a host image, starts the PE,
// serves its BRAM accesses while it runs, then streams the result region back to the host.
module bram_host_responder #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 13,
    parameter int LOAD_WORDS   = 4160,
    parameter int RESULT_BASE  = 0,
    parameter int RESULT_WORDS = 64,
    parameter int RD_LATENCY   = 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [31:0]           bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_wrdata,
    input  logic [3:0]            bram_we,
    output logic [DATA_WIDTH-1:0] bram_rddata,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  pe_start,
    input  logic                  pe_done,
    output logic                  busy,
    output logic                  err_len,
    output logic                  err_oob
);
    localparam int FIFO_D = RD_LATENCY + 1;
    localparam int PTR_W  = (FIFO_D > 2) ? $clog2(FIFO_D) : 1;
    localparam int OCC_W  = $clog2(FIFO_D + 1);
    localparam int CNT_W  = $clog2(RESULT_WORDS + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_DRAIN} state_t;
    state_t state, state_nx;

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] skid_mem [0:FIFO_D-1];
    logic [ADDR_WIDTH-1:0] ptr, bram_word, drain_addr, rd_addr, wr_idx;
    logic [CNT_W-1:0]      iss_cnt, beat_cnt;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [OCC_W-1:0]      occ;
    logic [DATA_WIDTH-1:0] rd_p0, rd_p1, rd_fin;
    logic                  vld_p0, vld_p1, ok_p0, ok_p1, vld_fin, ok_fin;
    logic                  bram_oob, load_acc, last_beat, len_bad, issue, push, pop;

    assign bram_word  = bram_addr[ADDR_WIDTH+1:2];
    assign bram_oob   = (bram_addr[31:ADDR_WIDTH+2] != '0) || (bram_addr[1:0] != 2'b00);
    assign s_ready    = aresetn && ((state == S_IDLE) || (state == S_LOAD));
    assign load_acc   = s_valid && s_ready;
    assign last_beat  = load_acc && (((state == S_LOAD) && (ptr == ADDR_WIDTH'(LOAD_WORDS - 1)))
                                  || ((state == S_IDLE) && (LOAD_WORDS == 1)));
    // Length error: final beat without s_last, or s_last arriving early.
    assign len_bad    = load_acc && (last_beat != s_last);
    assign drain_addr = ADDR_WIDTH'(RESULT_BASE) + ADDR_WIDTH'(iss_cnt);
    assign rd_addr    = (state == S_DRAIN) ? drain_addr : bram_word;
    assign wr_idx     = (state == S_IDLE) ? '0 : ptr;

    assign rd_fin  = (RD_LATENCY == 2) ? rd_p1 : rd_p0;
    assign vld_fin = (RD_LATENCY == 2) ? vld_p1 : vld_p0;
    assign ok_fin  = (RD_LATENCY == 2) ? ok_p1 : ok_p0;
    assign push    = vld_fin;
    assign m_valid = (occ != '0);
    assign pop     = m_valid && m_ready;
    assign m_data  = m_valid ? skid_mem[rd_ptr] : '0;
    assign m_last  = m_valid && (beat_cnt == CNT_W'(RESULT_WORDS - 1));
    assign busy    = (state != S_IDLE);
    assign bram_rddata = ok_fin ? rd_fin : '0;

    // Credit check: buffered + in-flight reads never exceed the skid depth.
    assign issue = (state == S_DRAIN) && (iss_cnt != CNT_W'(RESULT_WORDS)) &&
                   ((int'(occ) + int'(vld_p0) + ((RD_LATENCY == 2) ? int'(vld_p1) : 0))
                    < (FIFO_D + int'(pop)));

    always_comb begin
        state_nx = state;
        pe_start = 1'b0;
        case (state)
            S_IDLE, S_LOAD: begin
                if (load_acc) begin
                    if (last_beat)   state_nx = S_START;
                    else if (s_last) state_nx = S_IDLE;
                    else             state_nx = S_LOAD;
                end
            end
            S_START: begin
                pe_start = 1'b1;
                state_nx = S_RUN;
            end
            S_RUN:   if (pe_done) state_nx = S_DRAIN;
            S_DRAIN: if (pop && m_last) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= S_IDLE;
            ptr      <= '0;
            err_len  <= 1'b0;
            err_oob  <= 1'b0;
            iss_cnt  <= '0;
            beat_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            ok_p0    <= 1'b0;
            ok_p1    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE)      ptr <= load_acc ? ADDR_WIDTH'(1) : '0;
            else if (load_acc)        ptr <= ptr + 1'b1;
            if (load_acc && (state == S_IDLE)) begin
                err_len <= len_bad;
                err_oob <= 1'b0;
            end else begin
                if (len_bad) err_len <= 1'b1;
                if ((state == S_RUN) && bram_oob) err_oob <= 1'b1;
            end
            if (state != S_DRAIN) begin
                iss_cnt  <= '0;
                beat_cnt <= '0;
            end else begin
                if (issue) iss_cnt  <= iss_cnt + 1'b1;
                if (pop)   beat_cnt <= beat_cnt + 1'b1;
            end
            if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_D - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_D - 1)) ? '0 : rd_ptr + 1'b1;
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
            // read pipeline p0 -> p1
            vld_p0 <= issue;
            ok_p0  <= (state == S_RUN) && !bram_oob;
            vld_p1 <= vld_p0;
            ok_p1  <= ok_p0;
        end
    end

    always_ff @(posedge aclk) begin
        rd_p0 <= mem[rd_addr];
        rd_p1 <= rd_p0;
        if (push) skid_mem[wr_ptr] <= rd_fin;
        if (load_acc) begin
            mem[wr_idx] <= s_data;
        end else if ((state == S_RUN) && !bram_oob) begin
            for (int i = 0; i < 4; i++)
                if (bram_we[i]) mem[bram_word][8*i +: 8] <= bram_wrdata[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_bram_host_responder.sv
// Directed bench for bram_host_responder: load, BRAM port vectors, drain, error and reset cases.
module tb_bram_host_responder;
    localparam int LW = 4160;
    localparam int RW = 64;
    localparam int RL = 1;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] bram_addr = '0;
    logic [31:0] bram_wrdata = '0;
    logic [3:0]  bram_we = '0;
    logic [31:0] bram_rddata;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        m_last;
    logic        pe_start;
    logic        pe_done = 1'b0;
    logic        busy, err_len, err_oob;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;

    bram_host_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(13), .LOAD_WORDS(LW),
        .RESULT_BASE(0), .RESULT_WORDS(RW), .RD_LATENCY(RL)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .bram_addr(bram_addr), .bram_wrdata(bram_wrdata), .bram_we(bram_we),
        .bram_rddata(bram_rddata),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .pe_start(pe_start), .pe_done(pe_done),
        .busy(busy), .err_len(err_len), .err_oob(err_oob)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) if (pe_start) start_cnt <= start_cnt + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
        logic [31:0] exp_rd;
        logic        exp_oob;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic load(input int n, input int last_idx);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = i;
            s_last  = (i == last_idx);
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic write_results(input logic [31:0] tag);
        for (int k = 0; k < RW; k++) begin
            bram_addr   = k * 4;
            bram_wrdata = tag | k;
            bram_we     = 4'hF;
            step();
        end
        bram_we   = 4'h0;
        bram_addr = '0;
    endtask

    task automatic pulse_done();
        pe_done = 1'b1;
        step();
        pe_done = 1'b0;
    endtask

    task automatic drain(input bit rnd, input logic [31:0] tag);
        int got = 0;
        int cyc = 0;
        bit first_seen = 1'b0;
        bit stall_prev = 1'b0;
        logic [31:0] pd = '0;
        logic pl = 1'b0;
        while (got < RW && cyc < 1000) begin
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!first_seen && m_valid) begin
                first_seen = 1'b1;
                chk("m_valid_rise_within_bound", 32'(cyc <= RL + 2), 32'd1);
            end
            if (stall_prev) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data", m_data, pd);
                chk("stall_last", 32'(m_last), 32'(pl));
            end
            if (m_valid && m_ready) begin
                chk($sformatf("beat%0d_data", got), m_data, tag | got);
                chk($sformatf("beat%0d_last", got), 32'(m_last), 32'(got == RW - 1));
                got++;
            end
            stall_prev = m_valid && !m_ready;
            pd = m_data;
            pl = m_last;
            step();
            cyc++;
        end
        m_ready = 1'b0;
        chk("drain_beat_count", got, RW);
        chk("drain_busy_after", 32'(busy), 32'd0);
        chk("drain_m_valid_after", 32'(m_valid), 32'd0);
        chk("drain_s_ready_after", 32'(s_ready), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s_ready"},  32'(s_ready), 32'd0);
        chk({tag, "_busy"},     32'(busy), 32'd0);
        chk({tag, "_pe_start"}, 32'(pe_start), 32'd0);
        chk({tag, "_m_valid"},  32'(m_valid), 32'd0);
        chk({tag, "_m_data"},   m_data, 32'd0);
        chk({tag, "_m_last"},   32'(m_last), 32'd0);
        chk({tag, "_err_len"},  32'(err_len), 32'd0);
        chk({tag, "_err_oob"},  32'(err_oob), 32'd0);
        chk({tag, "_rddata"},   bram_rddata, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{32'h10,   32'h0,        4'h0, 32'h4,        1'b0};
        vecs[1]  = '{32'h10,   32'hDEADBEEF, 4'h3, 32'h4,        1'b0};
        vecs[2]  = '{32'h10,   32'h0,        4'h0, 32'h0000BEEF, 1'b0};
        vecs[3]  = '{32'h20,   32'h12345678, 4'hF, 32'h8,        1'b0};
        vecs[4]  = '{32'h20,   32'h0,        4'h0, 32'h12345678, 1'b0};
        vecs[5]  = '{32'h14,   32'hAABBCCDD, 4'hC, 32'h5,        1'b0};
        vecs[6]  = '{32'h14,   32'h0,        4'h0, 32'hAABB0005, 1'b0};
        vecs[7]  = '{32'hFC,   32'h0,        4'h0, 32'h3F,       1'b0};
        vecs[8]  = '{32'h8000, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vecs[9]  = '{32'h0,    32'h0,        4'h0, 32'h0,        1'b1};
        vecs[10] = '{32'h11,   32'h11111111, 4'hF, 32'h0,        1'b1};
        vecs[11] = '{32'h10,   32'h0,        4'h0, 32'h0000BEEF, 1'b1};

        repeat (3) step();
        check_all_zero("reset");
        aresetn = 1'b1;
        #1;
        chk("post_reset_s_ready", 32'(s_ready), 32'd1);
        chk("post_reset_busy", 32'(busy), 32'd0);

        load(LW, LW - 1);
        chk("load1_pe_start", 32'(pe_start), 32'd1);
        chk("load1_busy", 32'(busy), 32'd1);
        chk("load1_err_len", 32'(err_len), 32'd0);
        chk("load1_s_ready_low", 32'(s_ready), 32'd0);
        step();
        chk("load1_pe_start_drop", 32'(pe_start), 32'd0);
        chk("load1_start_count", start_cnt, 32'd1);

        for (int i = 0; i < 12; i++) begin
            bram_addr   = vecs[i].addr;
            bram_wrdata = vecs[i].wdata;
            bram_we     = vecs[i].we;
            step();
            chk($sformatf("vec%0d_rddata", i), bram_rddata, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err_oob", i), 32'(err_oob), 32'(vecs[i].exp_oob));
        end
        bram_we   = 4'h0;
        bram_addr = '0;

        write_results(32'hA5000000);
        chk("run_err_oob_sticky", 32'(err_oob), 32'd1);
        pulse_done();
        drain(1'b0, 32'hA5000000);
        chk("idle_rddata_zero", bram_rddata, 32'd0);
        chk("idle_err_oob_held", 32'(err_oob), 32'd1);

        load(101, 100);
        chk("short_err_len", 32'(err_len), 32'd1);
        chk("short_err_oob_cleared", 32'(err_oob), 32'd0);
        chk("short_busy", 32'(busy), 32'd0);
        step();
        chk("short_no_start", start_cnt, 32'd1);
        chk("short_still_idle", 32'(busy), 32'd0);

        load(LW, LW - 1);
        chk("load2_pe_start", 32'(pe_start), 32'd1);
        chk("load2_err_len_clear", 32'(err_len), 32'd0);
        step();
        write_results(32'h5A000000);
        pulse_done();
        drain(1'b1, 32'h5A000000);

        load(LW, LW - 1);
        step();
        pulse_done();
        repeat (5) step();
        chk("stall_drain_m_valid", 32'(m_valid), 32'd1);
        chk("stall_drain_m_data", m_data, 32'd0);
        chk("stall_drain_busy", 32'(busy), 32'd1);
        aresetn = 1'b0;
        step();
        check_all_zero("mid_drain_reset");
        aresetn = 1'b1;
        #1;
        chk("mid_drain_reset_s_ready", 32'(s_ready), 32'd1);
        step();
        chk("mid_drain_reset_idle", 32'(busy), 32'd0);
        chk("final_start_count", start_cnt, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bram_host_responder.md
Name: bram_host_responder

Overview:
- Responder (slave) end of the PE controller's 32-bit byte-addressed BRAM port.
- Host side:
  - streams a matrix+vector image into a local word memory;
  - pulses the PE controller's start;
  - serves its BRAM reads and writes while it runs;
  - on pe_done, streams the result region back to the host.
- Sits between the host DMA/stream fabric and pe_con; replaces the external BRAM plus glue.

Parameters:
- DATA_WIDTH, 32, word width (fixed 32; byte enables assume 4 bytes).
- ADDR_WIDTH, 13, word-address width; memory depth 2^ADDR_WIDTH words.
- LOAD_WORDS, 4160, words per load image (64*64 matrix + 64 vector), written from word 0.
- RESULT_BASE, 0, first word index of the result region.
- RESULT_WORDS, 64, words streamed back after pe_done.
- RD_LATENCY, 1, BRAM-port read latency in cycles (1 or 2).

Ports:
- aclk, in, 1, clock.
- aresetn, in, 1, reset.
- bram_addr, in, 32, byte address from PE controller; word index = bram_addr[ADDR_WIDTH+1:2].
- bram_wrdata, in, 32, write data.
- bram_we, in, 4, per-byte write enable.
- bram_rddata, out, 32, read data.
- s_valid, in, 1, host load beat valid.
- s_ready, out, 1, load beat accepted when s_valid & s_ready.
- s_data, in, 32, load word.
- s_last, in, 1, host marks final load beat.
- m_valid, out, 1, readback beat valid.
- m_ready, in, 1, host accepts readback beat.
- m_data, out, 32, result word.
- m_last, out, 1, final readback beat.
- pe_start, out, 1, one-cycle start pulse to PE controller.
- pe_done, in, 1, done pulse from PE controller.
- busy, out, 1, high in every state except S_IDLE.
- err_len, out, 1, sticky load-length error.
- err_oob, out, 1, sticky out-of-range BRAM-port access.

Behaviour:
- Reset: aresetn, synchronous, active-low; clock aclk.
  - In reset: state = S_IDLE; all outputs 0 except s_ready = 1 after reset releases; pointers 0.
  - Memory contents are not cleared.
  - Reset mid-operation aborts any state immediately, with the same values.
- Single-port word memory; host load, BRAM port and drain are mutually exclusive by state.
- S_IDLE:
  - s_ready = 1.
  - An accepted beat writes word 0, sets ptr = 1, clears err_len/err_oob, and goes to S_LOAD.
  - If LOAD_WORDS == 1, it goes to S_START instead.
- S_LOAD:
  - s_ready = 1; each accepted beat writes mem[ptr] and increments ptr.
  - Beat at ptr == LOAD_WORDS-1 is accepted, then go to S_START. If s_last = 0 on that beat, set err_len and proceed.
  - s_last = 1 on an earlier beat: accept the beat, set err_len, go to S_IDLE, no start.
  - s_valid low: hold; no timeout.
- S_START: pe_start = 1 for exactly one cycle, then S_RUN. s_ready = 0 from here through S_DRAIN.
- S_RUN (BRAM port serviced):
  - Write: each byte i with bram_we[i] = 1 updates bits 8i+7:8i in the same cycle.
  - Read: every cycle, bram_rddata = mem[word] registered, RD_LATENCY cycles after the address.
  - Read-first: a same-address read and write return the old data.
  - Out of range (bram_addr[31:ADDR_WIDTH+2] != 0 or bram_addr[1:0] != 0): write dropped, read returns 0, err_oob set.
  - The port is serviced in the cycle pe_done is sampled; next state is S_DRAIN.
- Outside S_RUN: BRAM writes ignored; bram_rddata = 0 after pipeline flush; pe_done ignored.
- S_DRAIN:
  - Reads RESULT_BASE .. RESULT_BASE+RESULT_WORDS-1 in order.
  - m_valid first rises within RD_LATENCY+2 cycles of entry.
  - A 2-entry skid buffer sustains 1 beat/cycle while m_ready = 1.
  - m_data/m_valid/m_last are stable while m_valid & !m_ready.
  - m_last = 1 only on beat RESULT_WORDS-1; after its handshake, go to S_IDLE.
  - No beat is lost or duplicated under arbitrary m_ready toggling.
- Word index arithmetic wraps modulo 2^ADDR_WIDTH (RESULT_BASE+k).

Test Plan:
- Reset then stream 4160 beats (data = index, s_last on beat 4159) → pe_start single pulse 1 cycle after the final accept; busy = 1; err_len = 0.
- In S_RUN, read byte addr 0x10 → bram_rddata = 4 exactly RD_LATENCY cycles later; write 0xDEADBEEF, we = 4'b0011, to 0x10 → next read returns 0x0000BEEF.
- Same-cycle read+write to addr 0x20 (old value 8) → returns 8, subsequent read returns the new value.
- Access to addr 0x0000_8000 → read returns 0, memory unchanged, err_oob = 1, stays 1 until the next load.
- Write 64 results at 0x0..0xFC, pulse pe_done, m_ready = 1 → 64 consecutive beats in order, m_last on the 64th, then S_IDLE; repeat with m_ready random 50% → identical sequence, stable data while stalled.
- s_last on beat 100 → err_len = 1, no pe_start, S_IDLE; assert aresetn = 0 mid-drain → all outputs 0, S_IDLE next cycle.
